posit_div_encoder: RTL

- Output stage of the posit divider datapath.
- Accepts the quotient sign, the scale difference, the 16-bit fraction quotient and the normalization flag from the approximate log-divider.
- Builds the regime/exponent/fraction bit string, rounds it round-to-nearest-even, applies the sign, and emits a packed posit<N,ES>.
- Two-stage pipeline with valid/ready on both sides.

---
 rtl/posit_pkg.sv | 26 ++
 rtl/posit_round_pack.sv | 60 ++++++
 rtl/posit_div_encoder.sv | 91 +++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared constants and the S1 pipeline word for the posit<16,1> divider output stage.
package posit_pkg;

    localparam int N         = 16;
    localparam int ES        = 1;
    localparam int SCALE_W   = 8;
    localparam int MAX_SCALE = (N - 2) * (2 ** ES);

    localparam logic signed [SCALE_W:0] MAX_SCALE_S = (SCALE_W + 1)'(MAX_SCALE);

    localparam logic [N-1:0] POSIT_NAR    = 16'h8000;
    localparam logic [N-1:0] POSIT_ZERO   = 16'h0000;
    localparam logic [N-1:0] POSIT_MAXPOS = 16'h7FFF;
    localparam logic [N-1:0] POSIT_MINPOS = 16'h0001;

    typedef struct packed {
        logic                      sign;
        logic signed [SCALE_W:0]   eff_scale;
        logic                      sat_hi;
        logic                      sat_lo;
        logic [N-1:0]              frac;
        logic                      zero;
        logic                      nar;
    } s1_word_t;

endpackage

// File: rtl/posit_round_pack.sv
// Combinational regime/exponent/fraction packer with round-to-nearest-even,
// saturation to maxpos/minpos and two's-complement sign application.
module posit_round_pack
    import posit_pkg::*;
(
    input  logic                    sign_i,
    input  logic signed [SCALE_W:0] eff_scale_i,
    input  logic [N-1:0]            frac_i,
    input  logic                    sat_hi_i,
    input  logic                    sat_lo_i,
    output logic [N-1:0]            posit_o
);

    // Wide enough for the longest regime plus exponent plus fraction.
    localparam int SW = 48;
    localparam logic [SCALE_W:0] ONE_S = {{SCALE_W{1'b0}}, 1'b1};

    logic signed [SCALE_W:0] k;
    logic [SCALE_W:0]        run_len;
    logic [SCALE_W:0]        reg_len;
    logic [SW-1:0]           regime_v;
    logic [SW-1:0]           payload_v;
    logic [SW-1:0]           str_v;
    logic [N-2:0]            body_t;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [N-1:0]            rounded;
    logic [N-1:0]            mag;

    always_comb begin
        k = eff_scale_i >>> ES;
        if (!k[SCALE_W]) begin
            run_len  = $unsigned(k) + ONE_S;
            regime_v = ~({SW{1'b1}} >> run_len);
        end else begin
            run_len  = $unsigned(-k);
            regime_v = {1'b1, {(SW - 1){1'b0}}} >> run_len;
        end
        // The terminating regime bit follows the run of identical bits.
        reg_len   = run_len + ONE_S;
        payload_v = {eff_scale_i[ES-1:0], frac_i, {(SW - N - ES){1'b0}}} >> reg_len;
        str_v     = regime_v | payload_v;

        body_t   = str_v[SW-1 -: (N - 1)];
        guard    = str_v[SW-N];
        sticky   = |str_v[SW-N-1:0];
        round_up = guard & (body_t[0] | sticky);
        rounded  = {1'b0, body_t} + {{(N - 1){1'b0}}, round_up};

        mag = rounded;
        if (sat_hi_i || rounded[N-1]) begin
            mag = POSIT_MAXPOS;
        end else if (sat_lo_i || (rounded == '0)) begin
            mag = POSIT_MINPOS;
        end
        posit_o = sign_i ? (-mag) : mag;
    end

endmodule

// File: rtl/posit_div_encoder.sv
// Two-stage output stage of the posit divider: S1 normalizes the scale and
// flags saturation, S2 packs and rounds the posit and holds it for downstream.
module posit_div_encoder
    import posit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic signed [SCALE_W-1:0] in_scale,
    input  logic [N-1:0]              in_frac,
    input  logic                      in_norm,
    input  logic                      in_zero,
    input  logic                      in_nar,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0]              out_posit
);

    logic                    s1_valid_q;
    s1_word_t                s1_q;
    s1_word_t                s1_d;
    logic                    out_valid_q;
    logic [N-1:0]            out_posit_q;
    logic [N-1:0]            out_posit_d;
    logic [N-1:0]            enc_posit;
    logic signed [SCALE_W:0] eff_scale;
    logic                    s2_free;

    // Handshake: a word moves when valid && ready on that side; out_valid and
    // out_posit hold while stalled; S1 moves whenever S2 is empty or emitting.
    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;

    always_comb begin
        eff_scale        = {in_scale[SCALE_W-1], in_scale} + {{SCALE_W{1'b0}}, in_norm};
        s1_d.sign        = in_sign;
        s1_d.eff_scale   = eff_scale;
        s1_d.sat_hi      = eff_scale > MAX_SCALE_S;
        s1_d.sat_lo      = eff_scale < -MAX_SCALE_S;
        s1_d.frac        = in_frac;
        s1_d.zero        = in_zero;
        s1_d.nar         = in_nar;
    end

    posit_round_pack u_round_pack (
        .sign_i      (s1_q.sign),
        .eff_scale_i (s1_q.eff_scale),
        .frac_i      (s1_q.frac),
        .sat_hi_i    (s1_q.sat_hi),
        .sat_lo_i    (s1_q.sat_lo),
        .posit_o     (enc_posit)
    );

    // NaR outranks zero, which outranks the encoded value.
    always_comb begin
        out_posit_d = enc_posit;
        if (s1_q.nar) begin
            out_posit_d = POSIT_NAR;
        end else if (s1_q.zero) begin
            out_posit_d = POSIT_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_free) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_posit_q <= out_posit_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_posit = out_posit_q;

endmodule
